// File: rtl/text_ram_arbiter.sv
// Text RAM port arbiter: display reads win, host cell RMW fills the gaps.
// Optional clear-screen engine enabled by defining TEXT_RAM_CLEAR_EN.
module text_ram_arbiter #(
    parameter int CELL_COUNT = 2400,
    parameter int WORD_AW    = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_req,
    input  logic [11:0]        disp_cell,
    output logic               disp_valid,
    output logic [31:0]        disp_data,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic               host_we,
    input  logic [11:0]        host_cell,
    input  logic [13:0]        host_wdata,
    output logic               host_done,
    output logic [13:0]        host_rdata,
    output logic               host_err,
    input  logic               clr_start,
    input  logic [13:0]        clr_fill,
    output logic               clr_busy,
    output logic [WORD_AW-1:0] ram_addr,
    output logic               ram_we,
    output logic [31:0]        ram_wdata,
    input  logic [31:0]        ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT, S_WR, S_FIN
    } state_t;

    localparam logic [11:0] CELL_LIM = 12'(CELL_COUNT);

    state_t       state, state_nx;
    logic         op_we, op_err;
    logic [11:0]  op_cell;
    logic [13:0]  op_wdata;
    logic [31:0]  rmw_word;
    logic [31:0]  new_word;
    logic         fsm_use, fsm_we;
    logic         accept, out_of_range;

    logic               clr_act;
    logic               clr_block;
    logic [WORD_AW-1:0] clr_addr;
    logic [31:0]        clr_word;

    assign out_of_range = host_cell >= CELL_LIM;
    assign accept       = host_valid && host_ready;
    assign disp_data    = ram_rdata;

    assign new_word = op_cell[0] ? {op_wdata, rmw_word[17:0]}
                                 : {rmw_word[31:18], op_wdata, rmw_word[3:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            op_we      <= 1'b0;
            op_err     <= 1'b0;
            op_cell    <= '0;
            op_wdata   <= '0;
            rmw_word   <= '0;
            host_rdata <= '0;
            disp_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            disp_valid <= disp_req;
            if (accept) begin
                op_we    <= host_we;
                op_cell  <= host_cell;
                op_wdata <= host_wdata;
                op_err   <= out_of_range;
                if (out_of_range)
                    host_rdata <= '0;
            end
            if (state == S_WAIT) begin
                rmw_word <= ram_rdata;
                if (!op_we)
                    host_rdata <= op_cell[0] ? ram_rdata[31:18]
                                             : ram_rdata[17:4];
            end
        end
    end

    always_comb begin
        state_nx   = state;
        host_ready = 1'b0;
        host_done  = 1'b0;
        host_err   = 1'b0;
        fsm_use    = 1'b0;
        fsm_we     = 1'b0;
        unique case (state)
            S_IDLE: begin
                host_ready = !clr_block;
                if (host_valid && !clr_block)
                    state_nx = out_of_range ? S_FIN : S_RD;
            end
            S_RD: begin
                if (!disp_req) begin
                    fsm_use  = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: state_nx = op_we ? S_WR : S_FIN;
            S_WR: begin
                if (!disp_req) begin
                    fsm_use  = 1'b1;
                    fsm_we   = 1'b1;
                    state_nx = S_FIN;
                end
            end
            S_FIN: begin
                host_done = 1'b1;
                host_err  = op_err;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (disp_req) begin
            ram_addr = disp_cell[WORD_AW:1];
        end else if (clr_act) begin
            ram_addr  = clr_addr;
            ram_we    = 1'b1;
            ram_wdata = clr_word;
        end else if (fsm_use) begin
            ram_addr  = op_cell[WORD_AW:1];
            ram_we    = fsm_we;
            ram_wdata = fsm_we ? new_word : '0;
        end
    end

`ifdef TEXT_RAM_CLEAR_EN
    localparam logic [WORD_AW-1:0] CLR_LAST = WORD_AW'(CELL_COUNT / 2 - 1);

    logic        clr_pend;
    logic        clr_go;
    logic        clr_take;
    logic [13:0] clr_val;

    // A start pulse that cannot run yet is parked until the FSM idles.
    assign clr_take  = clr_start && !clr_busy && !clr_pend;
    assign clr_go    = (clr_start || clr_pend) && !clr_busy && state == S_IDLE;
    assign clr_block = clr_busy || clr_pend || clr_start;
    assign clr_act   = clr_busy && !disp_req;
    assign clr_word  = {clr_val, clr_val, 4'b0000};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_busy <= 1'b0;
            clr_pend <= 1'b0;
            clr_addr <= '0;
            clr_val  <= '0;
        end else begin
            if (clr_take)
                clr_val <= clr_fill;
            if (clr_go) begin
                clr_busy <= 1'b1;
                clr_pend <= 1'b0;
                clr_addr <= '0;
            end else if (clr_take) begin
                clr_pend <= 1'b1;
            end
            if (clr_act) begin
                clr_addr <= clr_addr + 1'b1;
                if (clr_addr == CLR_LAST) begin
                    clr_busy <= 1'b0;
                    clr_addr <= '0;
                end
            end
        end
    end
`else
    logic unused_clr;

    assign unused_clr = ^{clr_start, clr_fill};
    assign clr_busy   = 1'b0;
    assign clr_block  = 1'b0;
    assign clr_act    = 1'b0;
    assign clr_addr   = '0;
    assign clr_word   = '0;
`endif

    logic unused_bits;
    assign unused_bits = disp_cell[0];

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Randomized bench for text_ram_arbiter against a cell-level shadow model.
// Exercises the clear engine when TEXT_RAM_CLEAR_EN is defined.
module tb_text_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [11:0] disp_cell;
    logic        disp_valid;
    logic [31:0] disp_data;
    logic        host_valid, host_ready, host_we;
    logic [11:0] host_cell;
    logic [13:0] host_wdata;
    logic        host_done;
    logic [13:0] host_rdata;
    logic        host_err;
    logic        clr_start;
    logic [13:0] clr_fill;
    logic        clr_busy;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_cell(disp_cell),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_we(host_we), .host_cell(host_cell),
        .host_wdata(host_wdata), .host_done(host_done),
        .host_rdata(host_rdata), .host_err(host_err),
        .clr_start(clr_start), .clr_fill(clr_fill), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // physical RAM: synchronous, read-before-write
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // shadow model: cells plus reserved nibble per word
    logic [13:0] sc [0:4095];
    logic [3:0]  sr [0:2047];

    function automatic logic [31:0] sw(int w);
        return {sc[2*w+1], sc[2*w], sr[w]};
    endfunction

    function automatic logic [31:0] merged(logic [11:0] c, logic [13:0] d);
        int w = int'(c >> 1);
        return c[0] ? {d, sc[2*w], sr[w]} : {sc[2*w+1], d, sr[w]};
    endfunction

    // display pattern per cycle after acceptance
    bit          pat   [0:63];
    logic [11:0] dcell [0:63];

    task automatic make_pat(input logic [11:0] c, input int dens);
        logic [11:0] d;
        for (int i = 0; i < 64; i++) begin
            pat[i] = (i >= 1 && i <= 40) ? ($urandom % 100 < dens) : 1'b0;
            d = 12'($urandom);
            if ((d >> 1) == (c >> 1)) d = d ^ 12'h020;
            dcell[i] = d;
        end
    endtask

    // completion cycle from the rules: one free cycle to read, one to
    // capture, one more free cycle to write, then the done cycle
    function automatic int exp_done(bit we, bit oor, output int wr_at);
        int n1, n2;
        wr_at = 0;
        if (oor) return 1;
        n1 = 1;
        while (pat[n1]) n1++;
        if (!we) return n1 + 2;
        n2 = n1 + 2;
        while (pat[n2]) n2++;
        wr_at = n2;
        return n2 + 1;
    endfunction

    int          obs_done_at, obs_we_at, obs_we_cnt;
    int          obs_ready_bad, obs_we_disp_bad, obs_disp_bad;
    logic        obs_err, obs_ready0;
    logic [13:0] obs_rdata;
    logic [31:0] obs_wdata;
    logic [10:0] obs_waddr;

    task automatic host_op(input bit we, input logic [11:0] c,
                           input logic [13:0] wd);
        bit          prev_req;
        logic [11:0] prev_cell;
        obs_done_at = 0; obs_we_at = 0; obs_we_cnt = 0;
        obs_ready_bad = 0; obs_we_disp_bad = 0; obs_disp_bad = 0;
        obs_err = 1'b0; obs_rdata = '0; obs_wdata = '0; obs_waddr = '0;
        @(posedge clk); #1;
        host_valid = 1'b1; host_we = we; host_cell = c; host_wdata = wd;
        disp_req = 1'b0;
        @(negedge clk);
        obs_ready0 = host_ready;
        prev_req = 1'b0; prev_cell = '0;
        for (int n = 1; n <= 60 && obs_done_at == 0; n++) begin
            @(posedge clk); #1;
            host_valid = 1'b0;
            disp_req = pat[n];
            disp_cell = dcell[n];
            @(negedge clk);
            if (host_ready) obs_ready_bad++;
            if (ram_we) begin
                obs_we_cnt++;
                obs_we_at = n;
                obs_wdata = ram_wdata;
                obs_waddr = ram_addr;
                if (disp_req) obs_we_disp_bad++;
            end
            if (disp_valid !== prev_req) obs_disp_bad++;
            else if (prev_req && disp_data !== sw(int'(prev_cell >> 1)))
                obs_disp_bad++;
            if (host_done) begin
                obs_done_at = n;
                obs_err = host_err;
                obs_rdata = host_rdata;
            end
            prev_req = disp_req;
            prev_cell = disp_cell;
        end
        @(posedge clk); #1;
        disp_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        disp_req = 1'b0; disp_cell = '0;
        host_valid = 1'b0; host_we = 1'b0; host_cell = '0; host_wdata = '0;
        clr_start = 1'b0; clr_fill = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (host_ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 11'd0) begin
            errors++;
            $display("FAIL reset_port: ready=%b we=%b addr=%0d want 1 0 0",
                     host_ready, ram_we, ram_addr);
        end
        checks++;
        if ({host_done, host_err, disp_valid, clr_busy} !== 4'b0000 ||
            host_rdata !== 14'd0) begin
            errors++;
            $display("FAIL reset_out: done/err/dv/busy=%b rdata=%h want 0000 0",
                     {host_done, host_err, disp_valid, clr_busy}, host_rdata);
        end
    endtask

    task automatic test_write_basic();
        logic [31:0] exp;
        mem[2] = 32'h0000_000F;
        sc[4] = '0; sc[5] = '0; sr[2] = 4'hF;
        make_pat(12'd5, 0);
        exp = merged(12'd5, 14'h2A55);
        host_op(1'b1, 12'd5, 14'h2A55);
        checks++;
        if (obs_ready0 !== 1'b1 || obs_ready_bad != 0) begin
            errors++;
            $display("FAIL wr_ready: idle=%b busy_hits=%0d want 1 0",
                     obs_ready0, obs_ready_bad);
        end
        checks++;
        if (obs_we_at != 3 || obs_we_cnt != 1) begin
            errors++;
            $display("FAIL wr_time: we_at=%0d cnt=%0d want 3 1",
                     obs_we_at, obs_we_cnt);
        end
        checks++;
        if (obs_wdata !== exp || obs_waddr !== 11'd2) begin
            errors++;
            $display("FAIL wr_data: %h@%0d want %h@2", obs_wdata, obs_waddr, exp);
        end
        checks++;
        if (obs_done_at != 4 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: at=%0d err=%b want 4 0", obs_done_at, obs_err);
        end
        sc[5] = 14'h2A55;
    endtask

    task automatic test_read_basic();
        make_pat(12'd5, 0);
        host_op(1'b0, 12'd5, 14'h0);
        checks++;
        if (obs_done_at != 3 || obs_err !== 1'b0 || obs_we_cnt != 0) begin
            errors++;
            $display("FAIL rd_done: at=%0d err=%b we=%0d want 3 0 0",
                     obs_done_at, obs_err, obs_we_cnt);
        end
        checks++;
        if (obs_rdata !== 14'h2A55) begin
            errors++;
            $display("FAIL rd_data: got %h want 2a55", obs_rdata);
        end
    endtask

    task automatic test_display_stall();
        logic [31:0] exp;
        make_pat(12'd100, 0);
        pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b1;
        exp = merged(12'd100, 14'h1234);
        host_op(1'b1, 12'd100, 14'h1234);
        checks++;
        if (obs_done_at != 7 || obs_we_at != 6 || obs_we_cnt != 1) begin
            errors++;
            $display("FAIL stall_time: done=%0d we_at=%0d cnt=%0d want 7 6 1",
                     obs_done_at, obs_we_at, obs_we_cnt);
        end
        checks++;
        if (obs_we_disp_bad != 0 || obs_disp_bad != 0 || obs_wdata !== exp) begin
            errors++;
            $display("FAIL stall_disp: we_clash=%0d disp_bad=%0d wd=%h want 0 0 %h",
                     obs_we_disp_bad, obs_disp_bad, obs_wdata, exp);
        end
        sc[100] = 14'h1234;
    endtask

    task automatic test_out_of_range();
        logic [11:0] cells [2];
        cells[0] = 12'd2400;
        cells[1] = 12'd4095;
        for (int i = 0; i < 2; i++) begin
            make_pat(cells[i], 0);
            host_op(i[0], cells[i], 14'h3FFF);
            checks++;
            if (obs_done_at != 1 || obs_err !== 1'b1 || obs_rdata !== 14'd0 ||
                obs_we_cnt != 0) begin
                errors++;
                $display("FAIL oor_%0d: done=%0d err=%b rd=%h we=%0d want 1 1 0 0",
                         cells[i], obs_done_at, obs_err, obs_rdata, obs_we_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int done_seen = 0;
        @(posedge clk); #1;
        host_valid = 1'b1; host_we = 1'b1; host_cell = 12'd37;
        host_wdata = ~sc[37];
        disp_req = 1'b0;
        @(posedge clk); #1 host_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1) begin
            errors++;
            $display("FAIL rstwr_reach: ram_we=%b want 1", ram_we);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b0 || host_done !== 1'b0) begin
            errors++;
            $display("FAIL rstwr_cut: we=%b done=%b want 0 0", ram_we, host_done);
        end
        repeat (3) begin
            @(negedge clk);
            if (host_done) done_seen++;
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (host_done) done_seen++;
        end
        checks++;
        if (host_ready !== 1'b1 || done_seen != 0) begin
            errors++;
            $display("FAIL rstwr_after: ready=%b dones=%0d want 1 0",
                     host_ready, done_seen);
        end
        make_pat(12'd37, 0);
        host_op(1'b0, 12'd37, 14'h0);
        checks++;
        if (obs_rdata !== sc[37]) begin
            errors++;
            $display("FAIL rstwr_kept: got %h want %h", obs_rdata, sc[37]);
        end
    endtask

    task automatic test_random();
        bit          we, oor;
        logic [11:0] c;
        logic [13:0] wd;
        logic [31:0] exp_w;
        int          exp_d, exp_at;
        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom);
            oor = ($urandom % 8) == 0;
            c = oor ? 12'(2400 + $urandom % 1696) : 12'($urandom % 2400);
            wd = 14'($urandom);
            make_pat(c, 40);
            exp_d = exp_done(we, oor, exp_at);
            exp_w = merged(c, wd);
            host_op(we, c, wd);
            checks++;
            if (obs_done_at != exp_d || obs_err !== oor) begin
                errors++;
                $display("FAIL rnd%0d_done: at=%0d err=%b want %0d %b",
                         t, obs_done_at, obs_err, exp_d, oor);
            end
            checks++;
            if (obs_we_cnt != ((we && !oor) ? 1 : 0) ||
                obs_we_disp_bad != 0 || obs_ready_bad != 0 || obs_disp_bad != 0) begin
                errors++;
                $display("FAIL rnd%0d_port: we=%0d clash=%0d rdy=%0d disp=%0d",
                         t, obs_we_cnt, obs_we_disp_bad, obs_ready_bad,
                         obs_disp_bad);
            end
            if (oor) begin
                checks++;
                if (obs_rdata !== 14'd0) begin
                    errors++;
                    $display("FAIL rnd%0d_oor: rd=%h want 0", t, obs_rdata);
                end
            end else if (we) begin
                checks++;
                if (obs_we_at != exp_at || obs_wdata !== exp_w ||
                    obs_waddr !== 11'(c >> 1)) begin
                    errors++;
                    $display("FAIL rnd%0d_wr: %h@%0d t%0d want %h@%0d t%0d",
                             t, obs_wdata, obs_waddr, obs_we_at, exp_w,
                             c >> 1, exp_at);
                end
                sc[c] = wd;
            end else begin
                checks++;
                if (obs_rdata !== sc[c]) begin
                    errors++;
                    $display("FAIL rnd%0d_rd: got %h want %h", t, obs_rdata, sc[c]);
                end
            end
        end
    endtask

    task automatic test_clear();
`ifdef TEXT_RAM_CLEAR_EN
        int wr = 0, bad = 0, bad_ready = 0;
        bit fin = 1'b0;
        @(posedge clk); #1;
        clr_start = 1'b1; clr_fill = 14'h0007; disp_req = 1'b0;
        @(negedge clk);
        checks++;
        if (clr_busy !== 1'b0 || host_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_start: busy=%b ready=%b want 0 0",
                     clr_busy, host_ready);
        end
        for (int n = 1; n <= 6000 && !fin; n++) begin
            @(posedge clk); #1;
            clr_start = 1'b0; clr_fill = 14'h3FFF;
            disp_req = 1'($urandom);
            disp_cell = 12'($urandom);
            @(negedge clk);
            if (wr == 1200) begin
                fin = 1'b1;
                checks++;
                if (clr_busy !== 1'b0 || ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_end: busy=%b we=%b want 0 0",
                             clr_busy, ram_we);
                end
            end else begin
                if (!clr_busy) bad++;
                if (host_ready) bad_ready++;
                if (ram_we === disp_req) bad++;
                if (ram_we) begin
                    if (ram_addr !== 11'(wr) || ram_wdata !== 32'h001C_0070) bad++;
                    wr++;
                end
            end
        end
        checks++;
        if (!fin || bad != 0 || bad_ready != 0) begin
            errors++;
            $display("FAIL clr_run: fin=%b writes=%0d bad=%0d ready_hits=%0d",
                     fin, wr, bad, bad_ready);
        end
        disp_req = 1'b0;
        for (int i = 0; i < 2400; i++) sc[i] = 14'h0007;
        for (int w = 0; w < 1200; w++) sr[w] = 4'h0;
        make_pat(12'd1999, 0);
        host_op(1'b0, 12'd1999, 14'h0);
        checks++;
        if (obs_rdata !== 14'h0007) begin
            errors++;
            $display("FAIL clr_read: got %h want 0007", obs_rdata);
        end
`else
        int bad = 0;
        @(posedge clk); #1;
        clr_start = 1'b1; clr_fill = 14'h0007; disp_req = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (clr_busy !== 1'b0 || host_ready !== 1'b1 || ram_we !== 1'b0) bad++;
            @(posedge clk); #1 clr_start = 1'b0;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clr_absent: %0d cycles showed clear activity", bad);
        end
`endif
    endtask

    initial begin
        rst = 1'b0;
        for (int w = 0; w < 2048; w++) begin
            logic [31:0] r;
            r = $urandom;
            mem[w] = r;
            sr[w] = r[3:0];
            sc[2*w] = r[17:4];
            sc[2*w+1] = r[31:18];
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_display_stall();
        test_out_of_range();
        test_reset_mid_write();
        test_random();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
